vpu_fp_rsqrt_seq: RTL and testbench
===================================

VPU_FP_RSQRT_SEQ -- requirements
Module: vpu_fp_rsqrt_seq

Interface
REQ-001 Parameter NUM_LANES, default 8: elements per vector operation.
REQ-002 Parameter OPERAND_WIDTH, default 16: element width; bf16 encoding.
REQ-003 Parameter TIMEOUT, default 64: watchdog limit in cycles with no core return while results are outstanding.
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 start_i  input  1  one-cycle request to begin a vector operation; accepted only in IDLE.
REQ-007 op_i  input  NUM_LANES*OPERAND_WIDTH  source vector; lane k at bits [k*OPERAND_WIDTH +: OPERAND_WIDTH].
REQ-008 mask_i  input  NUM_LANES  lane enable; 1 = compute lane.
REQ-009 busy_o  output  1  high in every state except IDLE.
REQ-010 core_valid_o  output  1  element issue strobe to the shared reciprocal-sqrt core.
REQ-011 core_data_o  output  OPERAND_WIDTH  element being issued.
REQ-012 core_valid_i  input  1  core result strobe.
REQ-013 core_data_i  input  OPERAND_WIDTH  core result; returns in issue order.
REQ-014 result_o  output  NUM_LANES*OPERAND_WIDTH  assembled result vector; lane layout as op_i.
REQ-015 done_o  output  1  one-cycle completion pulse.
REQ-016 err_o  output  1  valid with done_o; set on watchdog expiry or spurious core return.

Function
REQ-017 FSM states: IDLE, ISSUE, DRAIN, DONE.
REQ-018 IDLE -> ISSUE on start_i; op_i and mask_i are captured the same cycle, and result register and err are cleared.
REQ-019 start_i outside IDLE is ignored and has no effect on the running operation.
REQ-020 ISSUE: issue exactly one enabled lane per cycle, ascending lane index; masked lanes are skipped with no issue cycle spent.
REQ-021 ISSUE -> DRAIN in the cycle after the last enabled lane issues.
REQ-022 All lanes masked: ISSUE -> DONE directly; no core_valid_o.
REQ-023 Outstanding counter (width clog2(NUM_LANES+1)): +1 per issue, -1 per core_valid_i, net 0 when both occur in the same cycle.
REQ-024 Each core result is written to the lowest enabled lane not yet written; a return-pointer skips masked lanes.
REQ-025 Masked lanes in result_o read 0.
REQ-026 DRAIN -> DONE when outstanding reaches 0 and ISSUE is complete; also permitted from ISSUE if the final return coincides.
REQ-027 DONE lasts one cycle: done_o=1, then -> IDLE; result_o holds until the next accepted start_i.
REQ-028 Watchdog counts cycles with outstanding>0 and no core_valid_i, and resets on any return; reaching TIMEOUT sets err, forces DONE, and discards later returns.
REQ-029 core_valid_i with outstanding=0 (any state) is dropped and sets err; if IDLE, err is reported with the next operation's done_o.
REQ-030 Minimum latency start_i->done_o = E + core latency + 1 cycles, where E = enabled lanes.

Reset
REQ-031 rst asserted at any time, including mid-operation: state=IDLE, counters=0, err=0, result_o=0, busy_o=0, done_o=0, core_valid_o=0, core_data_o=0, effective immediately (async).
REQ-032 Core returns arriving after rst deassertion from pre-reset issues are treated per REQ-029.

Structure
REQ-033 State enum, NUM_LANES and OPERAND_WIDTH defaults belong in VPU_PKG.
REQ-034 One sub-module: vpu_fp_rsqrt_core (sqrt followed by divide of 1.0 by the root, in-order, fully pipelined), instantiated by the parent VPU wrapper, not inside this block.

Verification
REQ-035 Mask 0xFF, lanes 4.0 (0x4080), core latency 20 -> 8 issues on consecutive cycles, every lane 0x3F00, done_o 29 cycles after start_i, err_o=0.
REQ-036 Mask 0x05, lane0=1.0, lane2=16.0 -> 2 issues; lane0=0x3F80, lane2=0x3E80, other lanes 0.
REQ-037 Mask 0x00 -> no core_valid_o; done_o 2 cycles after start_i; result_o all 0.
REQ-038 Core model withholds the 3rd return -> done_o with err_o=1 after 64 idle cycles; late return dropped.
REQ-039 rst pulsed mid-DRAIN, then new start_i -> outputs zero during reset; stale returns set err_o; second operation's lanes are correct.
REQ-040 start_i held high for whole operation -> exactly one operation runs; a new operation starts in the cycle after done_o.

Source files
------------

// File: rtl/vpu_pkg.sv
// Shared VPU definitions: lane/element defaults and the
// sequencer FSM state encoding for vector rsqrt.
package vpu_pkg;

  localparam int unsigned VPU_NUM_LANES     = 8;
  localparam int unsigned VPU_OPERAND_WIDTH = 16;
  localparam int unsigned VPU_RSQRT_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } rsqrt_state_e;

endpackage

// File: rtl/vpu_fp_rsqrt_seq.sv
// Vector rsqrt sequencer: feeds enabled bf16 lanes one per cycle
// to a shared in-order rsqrt core and reassembles the results.
// Ports: clk/rst, start_i/op_i/mask_i (request), busy_o,
// core_valid_o/core_data_o (issue), core_valid_i/core_data_i
// (return), result_o/done_o/err_o (completion).
module vpu_fp_rsqrt_seq
  import vpu_pkg::*;
#(
  parameter int unsigned NUM_LANES     = VPU_NUM_LANES,
  parameter int unsigned OPERAND_WIDTH = VPU_OPERAND_WIDTH,
  parameter int unsigned TIMEOUT       = VPU_RSQRT_TIMEOUT
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start_i,
  input  logic [NUM_LANES*OPERAND_WIDTH-1:0] op_i,
  input  logic [NUM_LANES-1:0]               mask_i,
  output logic                               busy_o,
  output logic                               core_valid_o,
  output logic [OPERAND_WIDTH-1:0]           core_data_o,
  input  logic                               core_valid_i,
  input  logic [OPERAND_WIDTH-1:0]           core_data_i,
  output logic [NUM_LANES*OPERAND_WIDTH-1:0] result_o,
  output logic                               done_o,
  output logic                               err_o
);

  localparam int unsigned VW = NUM_LANES * OPERAND_WIDTH;
  localparam int unsigned OW = OPERAND_WIDTH;
  localparam int unsigned CW = $clog2(NUM_LANES + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [NUM_LANES-1:0] ONE_L = NUM_LANES'(1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  rsqrt_state_e         state_q, state_d;
  logic [VW-1:0]        op_q, op_d;
  logic [VW-1:0]        res_q, res_d;
  logic [NUM_LANES-1:0] iss_rem_q, iss_rem_d;
  logic [NUM_LANES-1:0] ret_rem_q, ret_rem_d;
  logic [CW-1:0]        out_q, out_d;
  logic [WW-1:0]        wd_q, wd_d;
  logic                 err_q, err_d;
  logic                 pend_q, pend_d;

  logic [NUM_LANES-1:0] iss_oh, ret_oh;
  logic [OW-1:0]        iss_data;
  logic                 issue, ret_ok, spur, wd_hit;

  // Lowest remaining bit selects the next lane; masked lanes
  // were never set, so they cost no cycle.
  always_comb begin
    iss_oh   = iss_rem_q & (~iss_rem_q + ONE_L);
    ret_oh   = ret_rem_q & (~ret_rem_q + ONE_L);
    issue    = (state_q == ST_ISSUE) && (iss_rem_q != '0);
    ret_ok   = core_valid_i && (out_q != '0);
    spur     = core_valid_i && (out_q == '0);
    wd_hit   = (out_q != '0) && !core_valid_i
               && (wd_q == WD_LAST);
    iss_data = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (iss_oh[k]) iss_data = op_q[k*OW +: OW];
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    res_d     = res_q;
    iss_rem_d = iss_rem_q;
    ret_rem_d = ret_rem_q;
    err_d     = err_q;
    pend_d    = pend_q;
    out_d     = out_q + CW'(issue) - CW'(ret_ok);
    wd_d      = '0;
    if ((out_q != '0) && !core_valid_i) wd_d = wd_q + 1'b1;
    if (issue) iss_rem_d = iss_rem_q & ~iss_oh;
    if (ret_ok) begin
      ret_rem_d = ret_rem_q & ~ret_oh;
      for (int k = 0; k < NUM_LANES; k++) begin
        if (ret_oh[k]) res_d[k*OW +: OW] = core_data_i;
      end
    end
    unique case (state_q)
      ST_IDLE: begin
        // A stray return while idle is charged to the next op.
        if (spur) pend_d = 1'b1;
        if (start_i) begin
          state_d   = ST_ISSUE;
          op_d      = op_i;
          iss_rem_d = mask_i;
          ret_rem_d = mask_i;
          res_d     = '0;
          err_d     = pend_q | spur;
          pend_d    = 1'b0;
        end
      end
      ST_ISSUE, ST_DRAIN: begin
        if (spur) err_d = 1'b1;
        if (wd_hit) begin
          // Abandon the op; anything still in flight becomes
          // a stray return and is dropped.
          err_d   = 1'b1;
          out_d   = '0;
          wd_d    = '0;
          state_d = ST_DONE;
        end else if (iss_rem_d == '0) begin
          state_d = (out_d == '0) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (spur) pend_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      res_q     <= '0;
      iss_rem_q <= '0;
      ret_rem_q <= '0;
      out_q     <= '0;
      wd_q      <= '0;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      res_q     <= res_d;
      iss_rem_q <= iss_rem_d;
      ret_rem_q <= ret_rem_d;
      out_q     <= out_d;
      wd_q      <= wd_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
    end
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign core_valid_o = issue;
  assign core_data_o  = issue ? iss_data : '0;
  assign result_o     = res_q;
  assign done_o       = (state_q == ST_DONE);
  assign err_o        = done_o & err_q;

endmodule

// File: tb/tb_vpu_fp_rsqrt_seq.sv
// Bench for vpu_fp_rsqrt_seq: in-order core model with fixed
// latency and a scoreboard of expected completions.
module tb_vpu_fp_rsqrt_seq;

  localparam int NL = 8;
  localparam int OW = 16;
  localparam int VW = NL * OW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [VW-1:0] op_i;
  logic [NL-1:0] mask_i;
  logic          busy_o;
  logic          core_valid_o;
  logic [OW-1:0] core_data_o;
  logic          core_valid_i;
  logic [OW-1:0] core_data_i;
  logic [VW-1:0] result_o;
  logic          done_o;
  logic          err_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [VW-1:0] res;
    logic          err;
    int            start;
    int            lat;
    bit            chk_res;
  } exp_t;

  typedef struct {
    logic [OW-1:0] d;
    int            due;
  } ret_t;

  exp_t          sb[$];
  ret_t          pipe[$];
  int            core_lat = 1;
  int            drop_idx = 0;
  int            n_ret = 0;
  int            n_iss = 0;
  int            iss_first = -1;
  int            iss_last = -1;
  bit            rel_late = 1'b0;
  bit            late_v = 1'b0;
  logic [OW-1:0] late_d;

  vpu_fp_rsqrt_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .op_i         (op_i),
    .mask_i       (mask_i),
    .busy_o       (busy_o),
    .core_valid_o (core_valid_o),
    .core_data_o  (core_data_o),
    .core_valid_i (core_valid_i),
    .core_data_i  (core_data_i),
    .result_o     (result_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "bench stalled");
  end

  // bf16 rsqrt for the values used; other codes get an
  // arbitrary but lane-distinct mapping.
  function automatic logic [OW-1:0] rsq(input logic [OW-1:0] x);
    case (x)
      16'h4080: return 16'h3F00;
      16'h3F80: return 16'h3F80;
      16'h4180: return 16'h3E80;
      16'h4000: return 16'h3F35;
      default:  return x ^ 16'h5A5A;
    endcase
  endfunction

  function automatic logic [VW-1:0] exp_vec(
    input logic [VW-1:0] op, input logic [NL-1:0] m);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < NL; k++)
      if (m[k]) v[k*OW +: OW] = rsq(op[k*OW +: OW]);
    return v;
  endfunction

  function automatic logic [VW-1:0] ramp(input logic [OW-1:0] b);
    logic [VW-1:0] v;
    for (int k = 0; k < NL; k++) v[k*OW +: OW] = b + OW'(k * 3);
    return v;
  endfunction

  task automatic chk(input string tag,
                     input logic [VW-1:0] obs,
                     input logic [VW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Core model: returns rsq(issue) core_lat cycles later, in
  // order; one return can be withheld and released later.
  initial begin
    ret_t r;
    core_valid_i = 1'b0;
    core_data_i  = '0;
    forever begin
      @(negedge clk);
      core_valid_i = 1'b0;
      core_data_i  = '0;
      if (rel_late && late_v) begin
        core_valid_i = 1'b1;
        core_data_i  = late_d;
        late_v       = 1'b0;
        rel_late     = 1'b0;
      end else if (pipe.size() > 0 && pipe[0].due <= cyc) begin
        r = pipe.pop_front();
        n_ret++;
        if (n_ret == drop_idx) begin
          late_d = r.d;
          late_v = 1'b1;
        end else begin
          core_valid_i = 1'b1;
          core_data_i  = r.d;
        end
      end
      if (core_valid_o) begin
        r.d   = rsq(core_data_o);
        r.due = cyc + core_lat;
        pipe.push_back(r);
        n_iss++;
        if (iss_first < 0) iss_first = cyc;
        iss_last = cyc;
      end
    end
  end

  // Completion monitor: pops the scoreboard on each done_o.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_o) begin
        chk("sb_has_entry", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("err_o", err_o, e.err);
          if (e.chk_res) chk("result_o", result_o, e.res);
          if (e.lat > 0) chk("latency", cyc - e.start, e.lat);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_op(input logic [NL-1:0] m,
                        input logic [VW-1:0] op,
                        input int lat, input logic e_err,
                        input bit cres, input int e_lat);
    exp_t e;
    @(negedge clk);
    core_lat  = lat;
    n_ret     = 0;
    n_iss     = 0;
    iss_first = -1;
    mask_i    = m;
    op_i      = op;
    start_i   = 1'b1;
    e.res     = exp_vec(op, m);
    e.err     = e_err;
    e.start   = cyc;
    e.lat     = e_lat;
    e.chk_res = cres;
    sb.push_back(e);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string tag);
    int k;
    k = 0;
    while (!done_o && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, done_o, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_cvalid"}, core_valid_o, 0);
    chk({tag, "_cdata"}, core_data_o, 0);
    chk({tag, "_result"}, result_o, 0);
  endtask

  initial begin
    logic [VW-1:0] v;
    exp_t e;
    int k;
    rst = 1'b1;
    start_i = 1'b0;
    op_i = '0;
    mask_i = '0;
    tick(3);
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // all lanes 4.0, latency 20
    run_op(8'hFF, {NL{16'h4080}}, 20, 1'b0, 1'b1, 29);
    wait_done(100, "full");
    chk("full_issues", n_iss, 8);
    chk("full_issue_span", iss_last - iss_first, 7);

    // sparse mask: 1.0 and 16.0
    v = {NL{16'h4000}};
    v[0*OW +: OW] = 16'h3F80;
    v[2*OW +: OW] = 16'h4180;
    run_op(8'h05, v, 3, 1'b0, 1'b1, 6);
    wait_done(50, "sparse");
    chk("sparse_issues", n_iss, 2);

    // scattered mask with issue/return overlap
    run_op(8'hA6, ramp(16'h4100), 1, 1'b0, 1'b1, 6);
    chk("overlap_busy", busy_o, 1);
    wait_done(50, "overlap");
    chk("overlap_issues", n_iss, 4);

    // nothing enabled
    run_op(8'h00, ramp(16'h4200), 5, 1'b0, 1'b1, 2);
    wait_done(20, "empty");
    chk("empty_issues", n_iss, 0);

    // withheld 3rd return -> watchdog
    drop_idx = 3;
    run_op(8'hFF, ramp(16'h4300), 4, 1'b1, 1'b0, 77);
    wait_done(200, "wdog");
    drop_idx = 0;
    rel_late = 1'b1;
    tick(3);
    chk("late_released", late_v, 0);
    v = ramp(16'h4400);
    v[0*OW +: OW] = 16'h4000;
    run_op(8'h01, v, 2, 1'b1, 1'b1, 4);
    wait_done(50, "after_late");
    run_op(8'h81, ramp(16'h4500), 5, 1'b0, 1'b1, 8);
    wait_done(50, "clean");

    // reset while draining
    run_op(8'hFF, ramp(16'h4600), 10, 1'b0, 1'b0, 0);
    tick(12);
    chk("drain_busy", busy_o, 1);
    rst = 1'b1;
    #1;
    sb.delete();
    chk_zero("midrst");
    tick(2);
    rst = 1'b0;
    k = 0;
    while (pipe.size() > 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("stale_drained", pipe.size(), 0);
    tick(2);
    run_op(8'h0F, ramp(16'h4700), 3, 1'b1, 1'b1, 8);
    wait_done(50, "post_rst");
    run_op(8'hF0, ramp(16'h4800), 2, 1'b0, 1'b1, 7);
    wait_done(50, "post_rst_clean");

    // start held high across an operation
    @(negedge clk);
    core_lat = 2;
    n_iss = 0;
    v = ramp(16'h4900);
    mask_i = 8'h03;
    op_i = v;
    start_i = 1'b1;
    e.res = exp_vec(v, 8'h03);
    e.err = 1'b0;
    e.start = cyc;
    e.lat = 5;
    e.chk_res = 1'b1;
    sb.push_back(e);
    wait_done(50, "held1");
    e.start = cyc + 1;
    sb.push_back(e);
    tick(1);
    chk("held_idle_gap", busy_o, 0);
    chk("held_one_op", n_iss, 2);
    tick(1);
    chk("held_restart_busy", busy_o, 1);
    chk("held_restart_issue", core_valid_o, 1);
    start_i = 1'b0;
    wait_done(50, "held2");

    tick(5);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
